regfile_wb_scheduler: RTL and testbench

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_wb_scheduler.sv | 159 +++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-back scheduler.
// Arbitrates N write-back requesters round-robin onto a single register-file
// write port with one cycle of registered latency, and keeps a per-register
// busy scoreboard that issue sets and write-back clears.
module regfile_wb_scheduler #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned N  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_data,
  output logic            rf_load,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned PW   = (N > 1) ? $clog2(N) : 1;

  // Arbitration state
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_c;
  logic            hs_c;
  logic [AW-1:0]   haddr_c;
  logic [DW-1:0]   hdata_c;
  int unsigned     best_c;
  int unsigned     dist_c;

  // Output stage
  logic            load_q, load_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   data_q, data_d;

  // Busy scoreboard
  logic [NREG-1:0] busy_q, busy_d;

  // Round-robin search: pick the valid requester closest to ptr going upward
  // mod N. Distance form avoids building a rotated copy of req_valid.
  always_comb begin
    best_c = N;
    dist_c = 0;
    gidx_c = '0;
    hs_c   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      dist_c = (i + N - 32'(ptr_q)) % N;
      if (req_valid[i] && (dist_c < best_c)) begin
        best_c = dist_c;
        gidx_c = PW'(i);
        hs_c   = 1'b1;
      end
    end
    if (reset) begin
      hs_c = 1'b0;
    end
  end

  // One-hot ready from the grant; the output stage never stalls
  always_comb begin
    req_ready = '0;
    if (hs_c) begin
      req_ready[gidx_c] = 1'b1;
    end
  end

  // Select the granted requester's address and data
  always_comb begin
    haddr_c = '0;
    hdata_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gidx_c == PW'(i)) begin
        haddr_c = req_addr[i*AW +: AW];
        hdata_c = req_data[i*DW +: DW];
      end
    end
  end

  // Next pointer: one past the winner after a handshake, otherwise hold
  always_comb begin
    ptr_d = ptr_q;
    if (hs_c) begin
      ptr_d = (gidx_c == PW'(N - 1)) ? '0 : gidx_c + 1'b1;
    end
  end

  // Output stage next state; writes to register 0 are accepted but dropped
  always_comb begin
    load_d  = hs_c && (haddr_c != '0);
    waddr_d = waddr_q;
    data_d  = data_q;
    if (load_d) begin
      waddr_d = haddr_c;
      data_d  = hdata_c;
    end
  end

  // Busy next state: clear on write-back, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (hs_c) begin
      busy_d[haddr_c] = 1'b0;
    end
    if (iss_valid && !reset) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Arbitration pointer register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Register-file write port register; reset discards any held write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_q  <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
    end else begin
      load_q  <= load_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
    end
  end

  // Busy scoreboard register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rf_load  = load_q;
  assign rf_waddr = waddr_q;
  assign rf_data  = data_q;

  // A source is also busy while its write is still on the write port
  always_comb begin
    rs1_busy = (rs1 != '0) && (busy_q[rs1] || (load_q && (waddr_q == rs1)));
    rs2_busy = (rs2 != '0) && (busy_q[rs2] || (load_q && (waddr_q == rs2)));
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_regfile_wb_scheduler;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned N    = 3;
  localparam int unsigned NREG = 1 << AW;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            rf_load;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_data;
  logic            iss_valid = 1'b0;
  logic [AW-1:0]   iss_rd = '0;
  logic [AW-1:0]   rs1 = '0;
  logic [AW-1:0]   rs2 = '0;
  logic            rs1_busy;
  logic            rs2_busy;

  regfile_wb_scheduler #(.DW(DW), .AW(AW), .N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_load   (rf_load),
    .rf_waddr  (rf_waddr),
    .rf_data   (rf_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer, busy table and the pending write-port value
  int          m_ptr;
  bit          m_busy[NREG];
  bit          m_load;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic int grant_of(input logic [N-1:0] v);
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (m_ptr + k) % int'(N);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] rs);
    if (rs == '0) return 1'b0;
    return m_busy[rs] || (m_load && (m_addr == rs));
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_load = 1'b0;
    m_addr = '0;
    m_data = '0;
    for (int r = 0; r < int'(NREG); r++) m_busy[r] = 1'b0;
  endtask

  task automatic model_edge();
    int g;
    logic [AW-1:0] a;
    g = grant_of(req_valid);
    m_load = 1'b0;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      if (a != '0) begin
        m_load = 1'b1;
        m_addr = a;
        m_data = req_data[g*DW +: DW];
      end
      m_busy[a] = 1'b0;
      m_ptr = (g + 1) % int'(N);
    end
    if (iss_valid && iss_rd != '0) m_busy[iss_rd] = 1'b1;
  endtask

  task automatic compare_model();
    int g;
    logic [N-1:0] e;
    e = '0;
    g = reset ? -1 : grant_of(req_valid);
    if (g >= 0) e[g] = 1'b1;
    chk("m_ready", req_ready, e);
    chk("m_rf_load", rf_load, m_load);
    if (m_load) begin
      chk("m_rf_waddr", rf_waddr, m_addr);
      chk("m_rf_data", rf_data, m_data);
    end
    chk("m_rs1_busy", rs1_busy, exp_busy(rs1));
    chk("m_rs2_busy", rs2_busy, exp_busy(rs2));
  endtask

  // Called at a falling edge with inputs already applied; returns at the next
  // falling edge after checking outputs and advancing the model.
  task automatic cycle();
    if (reset) model_reset();
    #1 compare_model();
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
  endtask

  task automatic idle();
    req_valid = '0;
    iss_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_reset();
    #1;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_rf_load", rf_load, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_data", rf_data, 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] seq [6];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;

    @(negedge clock);
    do_reset();

    // Single write from requester 0
    set_req(0, 5'd5, 32'hA5A5_0001);
    #1 chk("t34_ready", req_ready, 3'b001);
    cycle();
    idle();
    #1;
    chk("t34_load", rf_load, 1'b1);
    chk("t34_waddr", rf_waddr, 5'd5);
    chk("t34_data", rf_data, 32'hA5A5_0001);
    cycle();
    #1 chk("t34_load_off", rf_load, 1'b0);

    // All requesters valid: round-robin 0,1,2,0,1,2
    do_reset();
    set_req(0, 5'd1, 32'h10);
    set_req(1, 5'd2, 32'h20);
    set_req(2, 5'd3, 32'h30);
    for (int k = 0; k < 6; k++) begin
      #1 chk("t35_grant", req_ready, seq[k]);
      cycle();
    end
    idle();
    cycle();

    // Write to register 0 is accepted but not performed
    set_req(1, 5'd0, 32'hFFFF_FFFF);
    #1 chk("t36_ready", req_ready, 3'b010);
    cycle();
    idle();
    #1 chk("t36_load", rf_load, 1'b0);
    cycle();

    // Issue then write-back to r7
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    cycle();
    idle();
    #1 chk("t37_busy_issued", rs1_busy, 1'b1);
    set_req(0, 5'd7, 32'h7777);
    cycle();
    idle();
    #1;
    chk("t37_load", rf_load, 1'b1);
    chk("t37_busy_wb", rs1_busy, 1'b1);
    cycle();
    #1 chk("t37_busy_clear", rs1_busy, 1'b0);

    // Issue and write-back to r9 at the same edge: set wins
    iss_valid = 1'b1; iss_rd = 5'd9;
    set_req(2, 5'd9, 32'h9999);
    cycle();
    idle();
    rs1 = 5'd9; rs2 = 5'd0;
    #1 chk("t38_busy_a", rs1_busy, 1'b1);
    cycle();
    #1;
    chk("t38_busy_b", rs1_busy, 1'b1);
    chk("t38_rs2_zero", rs2_busy, 1'b0);

    // Reset with a write held in the output stage
    iss_valid = 1'b1; iss_rd = 5'd4;
    cycle();
    idle();
    set_req(1, 5'd3, 32'h3333);
    cycle();
    idle();
    req_valid = 3'b111;
    rs1 = 5'd4; rs2 = 5'd3;
    #1 chk("t39_pre_load", rf_load, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t39_load", rf_load, 1'b0);
    chk("t39_busy1", rs1_busy, 1'b0);
    chk("t39_busy2", rs2_busy, 1'b0);
    chk("t39_ready", req_ready, 3'b000);
    @(negedge clock);
    cycle();
    reset = 1'b0;
    #1 chk("t39_first_grant", req_ready, 3'b001);
    chk("t39_no_load", rf_load, 1'b0);
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(63) == 0);
      req_valid = N'($urandom());
      for (int i = 0; i < int'(N); i++) begin
        req_addr[i*AW +: AW] = AW'($urandom_range(7));
        req_data[i*DW +: DW] = DW'($urandom());
      end
      iss_valid = ($urandom_range(1) == 1);
      iss_rd    = AW'($urandom_range(7));
      rs1       = AW'($urandom_range(7));
      rs2       = AW'($urandom_range(7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
